// File: rtl/detect_share_ctrl.sv
// detect_share_ctrl: round-robin front end that time-shares one detect_3zero
// serial detector between two word-level requesters. A granted word is
// preceded by a detector clear, shifted MSB-first, and the number of bit
// positions after which the detector fired is returned with the requester id.
module detect_share_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_reset,
  output logic             det_bitin,
  input  logic             det_indicator,
  output logic             out_valid,
  output logic             out_id,
  output logic [CNT_W-1:0] out_hits,
  input  logic             out_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [2:0]       state_q,     state_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic             id_q,        id_d;
  logic             last_id_q,   last_id_d;
  logic [CNT_W-1:0] hits_q,      hits_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic             det_reset_q, det_reset_d;
  logic             det_bitin_q, det_bitin_d;

  logic grant;
  logic accept;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_id_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == S_IDLE) && !grant;
  assign req1_ready = (state_q == S_IDLE) && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Sequencing of one word: accept, clear detector, shift bits, drain, report.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    hits_d      = hits_q;
    bit_cnt_d   = bit_cnt_q;
    det_bitin_d = 1'b1;
    det_reset_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d   = grant ? req1_data : req0_data;
          id_d      = grant;
          hits_d    = '0;
          bit_cnt_d = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // The indicator seen in shift cycle n reflects bit n-1, so the first
        // shift cycle has nothing of this word to count yet.
        if ((bit_cnt_q != '0) && det_indicator) begin
          hits_d = hits_q + ONE;
        end
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_DRAIN;
        end else begin
          bit_cnt_d = bit_cnt_q + ONE;
        end
      end
      S_DRAIN: begin
        if (det_indicator) begin
          hits_d = hits_q + ONE;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          last_id_d = id_q;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The registered bit output leads the state by one cycle, so the next bit
    // is loaded whenever the coming cycle is a shift cycle.
    if (state_d == S_SHIFT) begin
      det_bitin_d = shreg_q[WIDTH-1];
      shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
    end
    det_reset_d = (state_d != S_CLEAR);
  end

  // State and datapath registers; reset also holds the detector in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      hits_q      <= '0;
      bit_cnt_q   <= '0;
      det_reset_q <= 1'b0;
      det_bitin_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      hits_q      <= hits_d;
      bit_cnt_q   <= bit_cnt_d;
      det_reset_q <= det_reset_d;
      det_bitin_q <= det_bitin_d;
    end
  end

  assign det_reset = det_reset_q;
  assign det_bitin = det_bitin_q;
  assign out_valid = (state_q == S_DONE);
  assign out_id    = id_q;
  assign out_hits  = hits_q;

endmodule

// File: tb/tb_detect_share_ctrl.sv
// tb_detect_share_ctrl: directed bench with a behavioural three-zero detector,
// an expected-result queue filled by the stimulus and a monitor that pops it.
module tb_detect_share_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             det_reset, det_bitin, det_indicator;
  logic             out_valid, out_id, out_ready;
  logic [CNT_W-1:0] out_hits;

  typedef struct {
    int id;
    int hits;
  } exp_t;

  exp_t exp_q[$];
  int   acc_id_q[$];
  int   acc_edge_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt0 = 0;
  int acc_cnt1 = 0;
  bit spacing_chk = 1'b0;
  int spacing_seen = 0;
  int last_acc_edge = 0;
  bit prev_valid = 1'b0;

  always #5 clock = ~clock;

  detect_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_reset(det_reset), .det_bitin(det_bitin), .det_indicator(det_indicator),
    .out_valid(out_valid), .out_id(out_id), .out_hits(out_hits), .out_ready(out_ready)
  );

  // Behavioural detect_3zero: indicator high once the last three bits were 0.
  logic [1:0] zrun;
  always_ff @(posedge clock or negedge det_reset) begin
    if (!det_reset) zrun <= 2'd0;
    else if (det_bitin) zrun <= 2'd0;
    else if (zrun != 2'd3) zrun <= zrun + 2'd1;
  end
  assign det_indicator = (zrun == 2'd3);

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept tracker: checks grant order and spacing between accepts.
  always @(negedge clock) begin
    if (reset) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        int id;
        id = (req1_valid && req1_ready) ? 1 : 0;
        checkOutput("grant_onehot", int'(req0_valid && req0_ready) + int'(req1_valid && req1_ready), 1);
        if (id == 0) acc_cnt0++;
        else acc_cnt1++;
        if (acc_id_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL accept_unexpected: got id %0d, expected no accept", id);
        end else begin
          checkOutput("accept_id", id, acc_id_q.pop_front());
        end
        if (spacing_chk) begin
          if (spacing_seen > 0) checkOutput("accept_spacing", cyc + 1 - last_acc_edge, WIDTH + 4);
          spacing_seen++;
        end
        last_acc_edge = cyc + 1;
        acc_edge_q.push_back(cyc + 1);
      end
    end
  end

  // Result monitor: latency on each rising out_valid, payload on each handshake.
  always @(negedge clock) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid && acc_edge_q.size() > 0) begin
        checkOutput("result_latency", cyc - acc_edge_q.pop_front(), WIDTH + 2);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL result_unexpected: got id %0d hits %0d, expected none", out_id, out_hits);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("out_id", int'(out_id), e.id);
          checkOutput("out_hits", int'(out_hits), e.hits);
        end
      end
      prev_valid = out_valid;
    end
  end

  // Offer one word, wait for its accept, optionally trace the bit stream.
  task automatic applyStimulus(input int id, input logic [WIDTH-1:0] data,
                               input int hits, input bit trace);
    bit done;
    exp_q.push_back('{id, hits});
    acc_id_q.push_back(id);
    if (id == 0) begin
      req0_data = data;
      req0_valid = 1'b1;
    end else begin
      req1_data = data;
      req1_valid = 1'b1;
    end
    #1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if ((id == 0) ? req0_ready : req1_ready) begin
        tick();
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got no ready, expected ready for id %0d", id);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end else if (trace) begin
      checkOutput("clear_det_reset", int'(det_reset), 0);
      checkOutput("clear_bitin", int'(det_bitin), 1);
      for (int k = WIDTH - 1; k >= 0; k--) begin
        tick();
        checkOutput("shift_bitin", int'(det_bitin), int'(data[k]));
        checkOutput("shift_det_reset", int'(det_reset), 1);
      end
      tick();
      checkOutput("drain_bitin", int'(det_bitin), 1);
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    checkOutput("results_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base0;
    int base;
    int vcnt;
    bit seen;
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = '0;
    req1_data = '0;
    out_ready = 1'b1;
    #2 reset = 1'b0;

    // Reset values and tie-break preference
    repeat (3) tick();
    checkOutput("rst_det_reset", int'(det_reset), 0);
    checkOutput("rst_det_bitin", int'(det_bitin), 1);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_id", int'(out_id), 0);
    checkOutput("rst_out_hits", int'(out_hits), 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checkOutput("rst_tie_req0_ready", int'(req0_ready), 1);
    checkOutput("rst_tie_req1_ready", int'(req1_ready), 0);
    req0_valid = 1'b0;
    #1;
    checkOutput("rst_solo_req1_ready", int'(req1_ready), 1);
    req1_valid = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("post_rst_det_reset", int'(det_reset), 1);
    checkOutput("post_rst_out_valid", int'(out_valid), 0);
    checkOutput("post_rst_det_bitin", int'(det_bitin), 1);
    req0_valid = 1'b1;
    #1;
    checkOutput("idle_req0_ready", int'(req0_ready), 1);
    req0_valid = 1'b0;

    // All-zero word from requester 0
    base0 = acc_cnt0;
    applyStimulus(0, 8'b00000000, 6, 1'b1);
    waitIdle();
    checkOutput("req0_single_accept", acc_cnt0 - base0, 1);

    // Back-to-back words: the clear keeps the trailing zeros from leaking
    spacing_chk = 1'b1;
    spacing_seen = 0;
    applyStimulus(0, 8'b11111100, 0, 1'b0);
    applyStimulus(0, 8'b01111111, 0, 1'b0);
    waitIdle();
    spacing_chk = 1'b0;

    // Requester 1 with a single run of three zeros
    applyStimulus(1, 8'b10010001, 1, 1'b1);
    waitIdle();

    // Both requesters valid continuously: grants alternate 0,1,0,1
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{0, 6});
      acc_id_q.push_back(0);
      exp_q.push_back('{1, 0});
      acc_id_q.push_back(1);
    end
    spacing_chk = 1'b1;
    spacing_seen = 0;
    base = acc_cnt0 + acc_cnt1;
    req0_data = 8'h00;
    req1_data = 8'hFF;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (acc_cnt0 + acc_cnt1 >= base + 4) break;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("alternate_accepts", acc_cnt0 + acc_cnt1 - base, 4);
    spacing_chk = 1'b0;
    waitIdle();

    // Consumer stalls for 5 cycles while requester 1 waits
    out_ready = 1'b0;
    applyStimulus(0, 8'b00010000, 3, 1'b0);
    exp_q.push_back('{1, 0});
    acc_id_q.push_back(1);
    req1_data = 8'hFF;
    req1_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    checkOutput("stall_result_arrives", int'(seen), 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_out_valid", int'(out_valid), 1);
      checkOutput("stall_out_id", int'(out_id), 0);
      checkOutput("stall_out_hits", int'(out_hits), 3);
      checkOutput("stall_req1_ready", int'(req1_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    base = acc_cnt1;
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt1 > base) break;
      tick();
    end
    req1_valid = 1'b0;
    waitIdle();

    // Reset pulse mid-shift aborts the word
    applyStimulus(1, 8'h00, 6, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    exp_q.delete();
    acc_id_q.delete();
    acc_edge_q.delete();
    checkOutput("abort_det_reset", int'(det_reset), 0);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_det_bitin", int'(det_bitin), 1);
    repeat (2) tick();
    checkOutput("abort_det_reset_held", int'(det_reset), 0);
    reset = 1'b1;
    tick();
    checkOutput("abort_release_det_reset", int'(det_reset), 1);
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) vcnt++;
      tick();
    end
    checkOutput("abort_no_result", vcnt, 0);
    applyStimulus(0, 8'b10010001, 1, 1'b1);
    waitIdle();

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
